// File: rtl/nco_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nco_pkg
// Description : Shared FSM state type and default parameter values for the
//               FM-modulated NCO transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package nco_pkg;

    localparam int c_acc_w   = 32;
    localparam int c_mod_w   = 16;
    localparam int c_dev_shl = 8;
    localparam int c_lut_aw  = 8;
    localparam int c_out_w   = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } nco_state_e;

endpackage
`default_nettype wire

// File: rtl/nco_sin_lut.sv
`default_nettype none
// ============================================================================
// Module      : nco_sin_lut
// Description : Quarter-wave sine magnitude ROM with registered output.
// Revision    : 1.0 - initial release
// ============================================================================
module nco_sin_lut #(
    parameter int LUT_AW = 8,
    parameter int OUT_W  = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [LUT_AW-1:0] i_addr,
    output logic [OUT_W-2:0]  o_mag
);

    localparam int c_depth = 2 ** LUT_AW;
    localparam int c_mag_w = OUT_W - 1;

    // Samples taken at half-step offsets so the quarter mirrors without
    // duplicating the zero or peak entry.
    function automatic logic [c_depth*c_mag_w-1:0] build_rom();
        logic [c_depth*c_mag_w-1:0] rom;
        real    amp;
        real    period;
        real    ang;
        integer val;
        rom    = '0;
        amp    = $itor(2 ** (OUT_W - 1) - 1);
        period = 2.0 ** (LUT_AW + 2);
        for (int k = 0; k < c_depth; k++) begin
            ang = 2.0 * 3.14159265358979323846 * ($itor(k) + 0.5) / period;
            val = $rtoi(amp * $sin(ang) + 0.5);
            rom[k*c_mag_w +: c_mag_w] = val[c_mag_w-1:0];
        end
        return rom;
    endfunction

    localparam logic [c_depth*c_mag_w-1:0] c_rom = build_rom();

    logic [c_mag_w-1:0] w_mag_d;
    logic [c_mag_w-1:0] r_mag_q;

    always_comb begin
        w_mag_d = c_rom[int'(i_addr)*c_mag_w +: c_mag_w];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mag_q <= '0;
        end else begin
            r_mag_q <= w_mag_d;
        end
    end

    assign o_mag = r_mag_q;

endmodule
`default_nettype wire

// File: rtl/nco_fm_tx.sv
`default_nettype none
// ============================================================================
// Module      : nco_fm_tx
// Description : Phase-accumulator NCO with FM deviation input, square-wave
//               and quarter-wave-LUT sine outputs, and wrap pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module nco_fm_tx
    import nco_pkg::*;
#(
    parameter int ACC_W   = c_acc_w,
    parameter int MOD_W   = c_mod_w,
    parameter int DEV_SHL = c_dev_shl,
    parameter int LUT_AW  = c_lut_aw,
    parameter int OUT_W   = c_out_w
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic [ACC_W-1:0]        i_carrier,
    input  logic                    i_carrier_ld,
    input  logic [ACC_W-1:0]        i_phase_ofs,
    input  logic signed [MOD_W-1:0] i_mod,
    input  logic                    i_mod_valid,
    output logic                    o_mod_ready,
    output logic                    o_sig,
    output logic signed [OUT_W-1:0] o_sin,
    output logic                    o_sin_valid,
    output logic                    o_wrap
);

    nco_state_e r_state_q, w_state_d;

    logic [ACC_W-1:0] r_carrier_q, w_carrier_d;
    logic [MOD_W-1:0] r_mod_q,     w_mod_d;
    logic [ACC_W-1:0] r_step_q,    w_step_d;
    logic [ACC_W-1:0] r_acc_q,     w_acc_d;
    logic [ACC_W-1:0] r_ofs_q,     w_ofs_d;
    logic [ACC_W-1:0] r_phase_q,   w_phase_d;
    logic             r_wrap_q,    w_wrap_d;
    logic             r_v1_q,      w_v1_d;
    logic             r_v2_q,      w_v2_d;
    logic             r_v3_q,      w_v3_d;
    logic             r_neg_q,     w_neg_d;
    logic [OUT_W-1:0] r_sin_q,     w_sin_d;

    logic             w_run_hold;
    logic             w_kill;
    logic             w_xfer;
    logic [ACC_W-1:0] w_dev;
    logic [ACC_W-1:0] w_acc_sum;
    logic [1:0]       w_quad;
    logic [LUT_AW-1:0] w_addr_raw;
    logic [LUT_AW-1:0] w_lut_addr;
    logic [OUT_W-2:0] w_lut_mag;
    logic [OUT_W-1:0] w_mag_ext;
    logic             w_unused_phase_lsb;

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            ST_IDLE:  if (i_en) w_state_d = ST_START;
            ST_START: w_state_d = i_en ? ST_RUN : ST_IDLE;
            ST_RUN:   if (!i_en) w_state_d = ST_IDLE;
            default:  w_state_d = ST_IDLE;
        endcase
    end

    assign w_run_hold = (r_state_q == ST_RUN) && (w_state_d == ST_RUN);
    assign w_kill     = (w_state_d == ST_IDLE);
    assign w_xfer     = i_mod_valid && (r_state_q == ST_RUN);

    always_comb begin
        w_carrier_d = i_carrier_ld ? i_carrier : r_carrier_q;

        w_mod_d = r_mod_q;
        if (r_state_q == ST_IDLE) begin
            w_mod_d = '0;
        end else if (w_xfer) begin
            w_mod_d = i_mod;
        end

        w_ofs_d = (r_state_q == ST_START) ? i_phase_ofs : r_ofs_q;
    end

    // Deviation is sign-extended before the shift so negative samples
    // pull the frequency below the carrier.
    assign w_dev     = {{(ACC_W-MOD_W){r_mod_q[MOD_W-1]}}, r_mod_q} << DEV_SHL;
    assign w_acc_sum = r_acc_q + r_step_q;

    always_comb begin
        w_step_d  = r_carrier_q + w_dev;
        w_acc_d   = w_run_hold ? w_acc_sum : '0;
        w_wrap_d  = w_run_hold && r_acc_q[ACC_W-1] && !w_acc_sum[ACC_W-1];
        w_v1_d    = w_run_hold;
        w_phase_d = w_run_hold ? (r_acc_q + r_ofs_q) : '0;
    end

    assign w_quad     = r_phase_q[ACC_W-1 -: 2];
    assign w_addr_raw = r_phase_q[ACC_W-3 -: LUT_AW];
    assign w_lut_addr = w_quad[0] ? ~w_addr_raw : w_addr_raw;
    assign w_unused_phase_lsb = ^r_phase_q[ACC_W-LUT_AW-3:0];

    nco_sin_lut #(
        .LUT_AW (LUT_AW),
        .OUT_W  (OUT_W)
    ) u_sin_lut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_addr (w_lut_addr),
        .o_mag  (w_lut_mag)
    );

    assign w_mag_ext = {1'b0, w_lut_mag};

    // Valid bits drop on the same edge the FSM falls back to IDLE.
    always_comb begin
        w_neg_d = w_quad[1];
        w_v2_d  = r_v1_q && !w_kill;
        w_v3_d  = r_v2_q && !w_kill;
        w_sin_d = '0;
        if (w_v3_d) begin
            w_sin_d = r_neg_q ? -w_mag_ext : w_mag_ext;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q   <= ST_IDLE;
            r_carrier_q <= '0;
            r_mod_q     <= '0;
            r_step_q    <= '0;
            r_acc_q     <= '0;
            r_ofs_q     <= '0;
            r_phase_q   <= '0;
            r_wrap_q    <= 1'b0;
            r_v1_q      <= 1'b0;
            r_v2_q      <= 1'b0;
            r_v3_q      <= 1'b0;
            r_neg_q     <= 1'b0;
            r_sin_q     <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_carrier_q <= w_carrier_d;
            r_mod_q     <= w_mod_d;
            r_step_q    <= w_step_d;
            r_acc_q     <= w_acc_d;
            r_ofs_q     <= w_ofs_d;
            r_phase_q   <= w_phase_d;
            r_wrap_q    <= w_wrap_d;
            r_v1_q      <= w_v1_d;
            r_v2_q      <= w_v2_d;
            r_v3_q      <= w_v3_d;
            r_neg_q     <= w_neg_d;
            r_sin_q     <= w_sin_d;
        end
    end

    assign o_mod_ready = (r_state_q == ST_RUN);
    assign o_sig       = r_phase_q[ACC_W-1];
    assign o_sin       = r_sin_q;
    assign o_sin_valid = r_v3_q;
    assign o_wrap      = r_wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_nco_fm_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_nco_fm_tx
// Description : Directed self-checking bench for nco_fm_tx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nco_fm_tx;
    import nco_pkg::*;

    logic               clk;
    logic               rst;
    logic               en;
    logic [31:0]        carrier;
    logic               carrier_ld;
    logic [31:0]        phase_ofs;
    logic signed [15:0] mod;
    logic               mod_valid;
    logic               mod_ready;
    logic               sig;
    logic signed [9:0]  sin_out;
    logic               sin_valid;
    logic               wrap;

    int n_checks = 0;
    int n_errors = 0;

    nco_fm_tx #(
        .ACC_W   (32),
        .MOD_W   (16),
        .DEV_SHL (8),
        .LUT_AW  (8),
        .OUT_W   (10)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_carrier    (carrier),
        .i_carrier_ld (carrier_ld),
        .i_phase_ofs  (phase_ofs),
        .i_mod        (mod),
        .i_mod_valid  (mod_valid),
        .o_mod_ready  (mod_ready),
        .o_sig        (sig),
        .o_sin        (sin_out),
        .o_sin_valid  (sin_valid),
        .o_wrap       (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int          sig_pat [4] = '{0, 0, 1, 1};
    int          sin_pat [4] = '{2, 511, -2, -511};
    logic [31:0] acc_snap;

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        carrier    = '0;
        carrier_ld = 1'b0;
        phase_ofs  = '0;
        mod        = '0;
        mod_valid  = 1'b0;
        tick();
        tick();

        check("rst_sig",   sig, 0);
        check("rst_sin",   longint'(sin_out), 0);
        check("rst_valid", sin_valid, 0);
        check("rst_wrap",  wrap, 0);
        check("rst_ready", mod_ready, 0);
        check("rst_state", int'(dut.r_state_q), int'(ST_IDLE));
        rst = 1'b0;

        // Quarter-cycle carrier: square wave 0,0,1,1 and a four-point sine
        carrier = 32'h4000_0000; carrier_ld = 1'b1;
        tick();
        carrier_ld = 1'b0;
        tick();
        check("step_c4", dut.r_step_q, 32'h4000_0000);
        en = 1'b1;
        tick();
        check("ready_start", mod_ready, 0);
        check("state_start", int'(dut.r_state_q), int'(ST_START));
        tick();
        check("ready_run", mod_ready, 1);
        check("acc_first", dut.r_acc_q, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("c4_sig",   sig,  sig_pat[i % 4]);
            check("c4_wrap",  wrap, (i % 4 == 3) ? 1 : 0);
            check("c4_valid", sin_valid, (i >= 2) ? 1 : 0);
            check("c4_sin",   longint'(sin_out), (i >= 2) ? sin_pat[(i - 2) % 4] : 0);
        end

        // Single +1 modulation transfer reaches step two edges later
        mod = 16'sd1; mod_valid = 1'b1;
        tick();
        mod_valid = 1'b0;
        check("step_pre", dut.r_step_q, 32'h4000_0000);
        tick();
        check("step_mod1", dut.r_step_q, 32'h4000_0100);
        acc_snap = dut.r_acc_q;
        tick();
        check("acc_mod1", dut.r_acc_q, 32'(acc_snap + 32'h4000_0100));

        // Enable drop: IDLE and outputs quiet on the next edge
        en = 1'b0;
        tick();
        check("drop_state", int'(dut.r_state_q), int'(ST_IDLE));
        check("drop_valid", sin_valid, 0);
        check("drop_sin",   longint'(sin_out), 0);
        check("drop_sig",   sig, 0);
        check("drop_ready", mod_ready, 0);
        check("drop_acc",   dut.r_acc_q, 0);
        tick();
        check("mod_clr", dut.r_mod_q, 0);

        // Negative net step: carrier 0x100 with mod -2 gives 0xFFFF_FF00
        carrier = 32'h0000_0100; carrier_ld = 1'b1;
        tick();
        carrier_ld = 1'b0;
        en = 1'b1;
        tick();
        check("neg_ready_start", mod_ready, 0);
        tick();
        mod = -16'sd2; mod_valid = 1'b1;
        tick();
        mod_valid = 1'b0;
        check("neg_acc1", dut.r_acc_q, 32'h0000_0100);
        tick();
        check("neg_step", dut.r_step_q, 32'hFFFF_FF00);
        check("neg_acc2", dut.r_acc_q, 32'h0000_0200);
        tick();
        check("neg_acc3", dut.r_acc_q, 32'h0000_0100);
        tick();
        check("neg_acc4", dut.r_acc_q, 32'h0000_0000);
        tick();
        check("neg_acc5", dut.r_acc_q, 32'hFFFF_FF00);
        check("neg_nowrap", wrap, 0);

        // Negative step wrap: 0xC000_0000 wraps on 0x8.. -> 0x4..
        en = 1'b0; carrier = 32'hC000_0000; carrier_ld = 1'b1;
        tick();
        carrier_ld = 1'b0;
        tick();
        en = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 7; i++) begin
            tick();
            check("negwrap", wrap, (i == 2 || i == 6) ? 1 : 0);
        end

        // Simultaneous carrier load and modulation transfer
        carrier = 32'h0000_1000; carrier_ld = 1'b1;
        mod = 16'sd3; mod_valid = 1'b1;
        tick();
        carrier_ld = 1'b0; mod_valid = 1'b0;
        check("both_pre", dut.r_step_q, 32'hC000_0000);
        tick();
        check("both_step", dut.r_step_q, 32'h0000_1300);

        // Half-cycle phase offset with zero step: constant outputs
        en = 1'b0;
        tick();
        carrier = 32'h0; carrier_ld = 1'b1; phase_ofs = 32'h8000_0000;
        tick();
        carrier_ld = 1'b0;
        tick();
        tick();
        en = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            check("ofs_sig",  sig, 1);
            check("ofs_wrap", wrap, 0);
            check("ofs_acc",  dut.r_acc_q, 0);
            if (i >= 2) begin
                check("ofs_sin", longint'(sin_out), -2);
            end
        end

        // Reset in the middle of RUN
        carrier = 32'h4000_0000; carrier_ld = 1'b1;
        tick();
        carrier_ld = 1'b0;
        tick();
        tick();
        tick();
        check("pre_rst_valid", sin_valid, 1);
        rst = 1'b1; carrier_ld = 1'b1; mod_valid = 1'b1;
        tick();
        rst = 1'b0; carrier_ld = 1'b0; mod_valid = 1'b0;
        check("mrst_sig",     sig, 0);
        check("mrst_sin",     longint'(sin_out), 0);
        check("mrst_valid",   sin_valid, 0);
        check("mrst_wrap",    wrap, 0);
        check("mrst_ready",   mod_ready, 0);
        check("mrst_carrier", dut.r_carrier_q, 0);
        check("mrst_state",   int'(dut.r_state_q), int'(ST_IDLE));
        tick();
        check("mrst_restart", int'(dut.r_state_q), int'(ST_START));
        check("mrst_ready2",  mod_ready, 0);
        tick();
        check("mrst_ready3",  mod_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
